// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC generator and its return-address stack.
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          INSTR_BYTES   = 4;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIR,
    SRC_HOLD,
    SRC_RAS,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address LIFO; push/pop/replace take effect on the clock edge, top is combinational.
// Overflow silently overwrites the oldest entry; pop when empty is ignored.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [XLEN-1:0]              push_dat_i,
  output logic [XLEN-1:0]              top_o,
  output logic [$clog2(RAS_DEPTH):0]   count_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_ptr_m1;
  logic            w_nonempty;
  logic            w_do_pop;
  logic            w_do_push;
  logic [PW-1:0]   w_wr_idx;

  assign w_ptr_m1   = r_ptr - PW'(1);
  assign w_nonempty = (r_count != '0);
  assign w_do_pop   = pop_i && w_nonempty;
  assign w_do_push  = push_i;
  // Coroutine (push+pop on a non-empty stack) overwrites the current top in place.
  assign w_wr_idx   = w_do_pop ? w_ptr_m1 : r_ptr;
  assign top_o      = r_mem[w_ptr_m1];
  assign count_o    = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_ptr <= r_ptr + PW'(1);
      if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      r_ptr   <= w_ptr_m1;
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with trap > redirect > stall > RAS > sequential next-PC selection.
// One-cycle latency from inputs to pc_o; stall holds PC and RAS, trap/redirect override stall.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        redirect_valid_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  input  logic                        trap_valid_i,
  input  logic [XLEN-1:0]             trap_vec_i,
  input  logic                        call_i,
  input  logic                        ret_i,
  output logic [XLEN-1:0]             pc_o,
  output logic [XLEN-1:0]             pc_plus4_o,
  output logic                        misaligned_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_count_o
);

  logic [XLEN-1:0]            r_pc;
  logic                       r_misaligned;
  logic [XLEN-1:0]            w_pc_plus4;
  logic [XLEN-1:0]            w_pc_next;
  logic [XLEN-1:0]            w_ras_top;
  logic [$clog2(RAS_DEPTH):0] w_ras_count;
  logic                       w_ras_upd;
  logic                       w_misaligned_next;
  pc_src_e                    w_src;

  assign w_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);
  // RAS only moves on cycles whose instruction is actually advancing, never on flushed or stalled ones.
  assign w_ras_upd  = !trap_valid_i && !redirect_valid_i && !stall_i;

  always_comb begin
    w_src = SRC_SEQ;
    if (trap_valid_i)                         w_src = SRC_TRAP;
    else if (redirect_valid_i)                w_src = SRC_REDIR;
    else if (stall_i)                         w_src = SRC_HOLD;
    else if (ret_i && (w_ras_count != '0))    w_src = SRC_RAS;
  end

  always_comb begin
    w_pc_next         = w_pc_plus4;
    w_misaligned_next = 1'b0;
    case (w_src)
      SRC_TRAP: begin
        w_pc_next         = {trap_vec_i[XLEN-1:2], 2'b00};
        w_misaligned_next = (trap_vec_i[1:0] != 2'b00);
      end
      SRC_REDIR: begin
        w_pc_next         = {redirect_pc_i[XLEN-1:2], 2'b00};
        w_misaligned_next = (redirect_pc_i[1:0] != 2'b00);
      end
      SRC_HOLD: w_pc_next = r_pc;
      SRC_RAS:  w_pc_next = w_ras_top;
      default:  w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_VEC;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_misaligned <= w_misaligned_next;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (w_ras_upd && call_i),
    .pop_i      (w_ras_upd && ret_i),
    .push_dat_i (w_pc_plus4),
    .top_o      (w_ras_top),
    .count_o    (w_ras_count)
  );

  assign pc_o         = r_pc;
  assign pc_plus4_o   = w_pc_plus4;
  assign misaligned_o = r_misaligned;
  assign ras_count_o  = w_ras_count;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parameterised program-counter generator for the fetch stage. It is the next generation of the single 32-bit PC register.
- Holds the current fetch PC and selects the next PC from four sources: trap vector, execute-stage redirect, return-address-stack (RAS) prediction, or sequential PC+4.
- Supports stall.
- Feeds instruction-memory address and IF/ID pipeline register.

Parameters:
- XLEN, 32, PC and address width (>= 8).
- RESET_VEC, 0, PC value loaded while reset is asserted.
- RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC and RAS (hazard/ memory wait).
- redirect_valid_i  input  1  execute-stage branch/jump resolution redirect.
- redirect_pc_i  input  XLEN  redirect target.
- trap_valid_i  input  1  exception/interrupt entry.
- trap_vec_i  input  XLEN  trap handler address.
- call_i  input  1  instruction at pc_o is a call (link to x1/x5); push pc_o+4.
- ret_i  input  1  instruction at pc_o is a return; predict from RAS top.
- pc_o  output  XLEN  current fetch PC (registered).
- pc_plus4_o  output  XLEN  pc_o+4, combinational.
- misaligned_o  output  1  registered pulse: last loaded redirect/trap target had bits[1:0] != 0.
- ras_count_o  output  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_o=RESET_VEC; misaligned_o=0; ras_count_o=0.
  - RAS pointer=0; RAS storage contents don't-care.
  - Deassertion takes effect at the next clk edge.
- Next-PC priority, evaluated each rising edge:
  1. trap_valid_i -> pc_o <= {trap_vec_i[XLEN-1:2],2'b00}.
  2. redirect_valid_i -> pc_o <= {redirect_pc_i[XLEN-1:2],2'b00}.
  3. stall_i -> pc_o holds.
  4. ret_i and ras_count_o != 0 -> pc_o <= RAS top.
  5. Otherwise -> pc_o <= pc_o+4.
- Latency: exactly one cycle from input sample to pc_o update. No bubbles are inserted by this block.
- Trap and redirect override stall. Trap wins over a same-cycle redirect.
- misaligned_o:
  - Set to 1 for exactly one cycle after a trap/redirect load whose source bits[1:0] != 0.
  - 0 after every other edge, including stalls.
- Arithmetic: pc+4 is modulo 2^XLEN. {1..1,00}+4 wraps to 0 with no flag.
- RAS update: only on a cycle with no trap, no redirect and no stall. Otherwise call_i/ret_i are ignored, which prevents duplicate pushes on stall and mis-pushes from flushed instructions.
- Push (call_i=1, ret_i=0):
  - Write pc_o+4 at ptr, ptr <= ptr+1 mod RAS_DEPTH.
  - count <= min(count+1, RAS_DEPTH).
  - When full, the oldest entry is silently overwritten (circular buffer).
- Pop (ret_i=1, call_i=0, count != 0):
  - Next PC = entry[ptr-1], ptr <= ptr-1, count <= count-1.
- Pop when empty: no state change; next PC = pc_o+4.
- call_i and ret_i together (coroutine):
  - Next PC = old top. Top entry is replaced with pc_o+4.
  - ptr and count unchanged.
  - If empty, behave as a plain push and fetch sequentially.
- The RAS is never flushed by redirect or trap. Mispredictions are corrected by the execute redirect.
- There is no internal FSM beyond the PC register and RAS pointer/count. All outputs are registered except pc_plus4_o.

Decomposition:
- Shared package pc_pkg:
  - XLEN default, RESET_VEC default.
  - INSTR_BYTES=4.
  - next-PC source enum {SRC_TRAP, SRC_REDIR, SRC_HOLD, SRC_RAS, SRC_SEQ}, which the bench also uses for checking.
- One sub-module, ras_stack: circular LIFO with push/pop/replace, parameters XLEN and RAS_DEPTH, outputs top and count.
- pc_gen contains the priority mux, PC register and misalignment flag.

Test Plan:
- Reset/sequential: hold rst_n=0 with RESET_VEC=0x0000_0100 -> pc_o=0x100. Release, 3 free cycles -> 0x104, 0x108, 0x10C.
- Stall vs redirect: stall_i=1 for 2 cycles at pc 0x10 -> pc_o stays 0x10. Then stall_i=1 with redirect_valid_i=1, redirect_pc_i=0x200 -> pc_o=0x200 next cycle.
- Priority/alignment: trap_valid_i=1, trap_vec_i=0x8000_0003, plus redirect 0x400 in the same cycle -> pc_o=0x8000_0000, misaligned_o=1 for one cycle only.
- Call/return: call_i at pc 0x1000, then jump to 0x2000, then ret_i at 0x2010 -> next pc_o=0x1004. ras_count_o goes 0->1->0.
- RAS overflow/underflow with RAS_DEPTH=4:
  - 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> count saturates at 4.
  - 4 returns yield 0x44, 0x34, 0x24, 0x14.
  - A 5th ret gives pc_o+4 with count remaining 0.
- Wrap and gating:
  - pc_o=0xFFFF_FFFC with no events -> 0x0000_0000.
  - call_i asserted during a 3-cycle stall -> exactly one push (count +1) after the stall releases.
